// File: rtl/ov7670_frame_capture.sv
// ov7670_frame_capture
//   Receives an OV7670 RGB565 stream and writes a cropped, decimated frame
//   into the VGA frame BRAM. The sensor pins (PCLK, VS, HS, DATA) are treated
//   as data: they are synchronised into i_clk and their edges are detected
//   there, so i_clk must run at least 4x PCLK.
//
//   Optional build macro: OV7670_TEST_PATTERN_EN. When defined, the port
//   i_test_mode is added. Setting it replaces the pixel data with 8 vertical
//   colour bars, leaving timing, addresses and valid unchanged.
//
//   Ports
//     i_clk, i_reset       system clock, asynchronous active-high reset
//     i_start_capture      pulse, arms a capture from IDLE
//     i_continuous         re-arm after each frame (sampled in DONE)
//     i_abort              pulse, return to IDLE (wins over start)
//     i_h_start/i_v_start  crop window origin, latched at VS fall
//     i_PCLK/i_VS/i_HS/i_DATA  raw sensor pins
//     o_pixel_data/o_h_addr/o_v_addr/o_valid  BRAM write port
//     o_present_state      0 IDLE,1 WAIT_VS,2 VS_ACTIVE,3 CAPTURE,4 DONE
//     o_frame_done/o_frame_err  one-cycle completion / truncation pulses
//     o_frame_cnt          completed frames, wraps
module ov7670_frame_capture #(
  parameter int DATA_WIDTH  = 8,
  parameter int SENS_H      = 640,
  parameter int SENS_V      = 480,
  parameter int OUT_H       = 320,
  parameter int OUT_V       = 240,
  parameter int H_DECIM     = 2,
  parameter int V_DECIM     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int PXL_WIDTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start_capture,
  input  logic                        i_continuous,
  input  logic                        i_abort,
  input  logic [$clog2(SENS_H)-1:0]   i_h_start,
  input  logic [$clog2(SENS_V)-1:0]   i_v_start,
  input  logic                        i_PCLK,
  input  logic                        i_VS,
  input  logic                        i_HS,
  input  logic [DATA_WIDTH-1:0]       i_DATA,
`ifdef OV7670_TEST_PATTERN_EN
  input  logic                        i_test_mode,
`endif
  output logic [PXL_WIDTH-1:0]        o_pixel_data,
  output logic [$clog2(OUT_H):0]      o_h_addr,
  output logic [$clog2(OUT_V):0]      o_v_addr,
  output logic                        o_valid,
  output logic [2:0]                  o_present_state,
  output logic                        o_frame_done,
  output logic                        o_frame_err,
  output logic [15:0]                 o_frame_cnt
);

  localparam int HW  = $clog2(SENS_H) + 1;
  localparam int VW  = $clog2(SENS_V) + 1;
  localparam int HAW = $clog2(OUT_H) + 1;
  localparam int VAW = $clog2(OUT_V) + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_VS   = 3'd1,
    VS_ACTIVE = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state;

  // Input synchronisers; all pins share the same depth so DATA stays aligned
  // with the PCLK edge it was captured on.
  logic [SYNC_STAGES-1:0]                 pclk_sync, vs_sync, hs_sync;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync;
  logic                                   pclk_d, vs_d, hs_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pclk_sync <= '0;
      vs_sync   <= '0;
      hs_sync   <= '0;
      data_sync <= '0;
      pclk_d    <= 1'b0;
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
    end else begin
      pclk_sync <= {pclk_sync[SYNC_STAGES-2:0], i_PCLK};
      vs_sync   <= {vs_sync[SYNC_STAGES-2:0], i_VS};
      hs_sync   <= {hs_sync[SYNC_STAGES-2:0], i_HS};
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_DATA};
      pclk_d    <= pclk_sync[SYNC_STAGES-1];
      vs_d      <= vs_sync[SYNC_STAGES-1];
      hs_d      <= hs_sync[SYNC_STAGES-1];
    end
  end

  logic                  pclk_s, vs_s, hs_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  pclk_rise, vs_rise, vs_fall, hs_rise, hs_fall;

  assign pclk_s    = pclk_sync[SYNC_STAGES-1];
  assign vs_s      = vs_sync[SYNC_STAGES-1];
  assign hs_s      = hs_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign pclk_rise = pclk_s & ~pclk_d;
  assign vs_rise   = vs_s & ~vs_d;
  assign vs_fall   = ~vs_s & vs_d;
  assign hs_rise   = hs_s & ~hs_d;
  assign hs_fall   = ~hs_s & hs_d;

  // Frame position and latched window origin
  logic [HW-1:0]             h_cnt;
  logic [VW-1:0]             v_cnt;
  logic [$clog2(SENS_H)-1:0] h_start_q;
  logic [$clog2(SENS_V)-1:0] v_start_q;
  logic                      phase;
  logic [DATA_WIDTH-1:0]     hi_byte;

  // Window / decimation decode for the pixel at the current h_cnt/v_cnt
  int             h_off, v_off;
  logic           h_keep, v_keep, v_last;
  logic [HAW-1:0] h_addr_nxt;
  logic [VAW-1:0] v_addr_nxt;
  logic [PXL_WIDTH-1:0] pix_nxt;

  always_comb begin
    h_off      = int'(h_cnt) - int'(h_start_q);
    v_off      = int'(v_cnt) - int'(v_start_q);
    h_keep     = (h_off >= 0) && (h_off < OUT_H*H_DECIM) && ((h_off % H_DECIM) == 0);
    v_keep     = (v_off >= 0) && (v_off < OUT_V*V_DECIM) && ((v_off % V_DECIM) == 0);
    v_last     = v_keep && ((v_off / V_DECIM) == OUT_V-1);
    h_addr_nxt = HAW'(h_off / H_DECIM);
    v_addr_nxt = VAW'(v_off / V_DECIM);
  end

`ifdef OV7670_TEST_PATTERN_EN
  localparam int BAR_W = (OUT_H/8 > 0) ? OUT_H/8 : 1;
  int                   bar_idx;
  logic [PXL_WIDTH-1:0] bar_color;

  always_comb begin
    bar_idx = int'(h_addr_nxt) / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    case (bar_idx)
      0:       bar_color = PXL_WIDTH'(16'hFFFF); // white
      1:       bar_color = PXL_WIDTH'(16'hFFE0); // yellow
      2:       bar_color = PXL_WIDTH'(16'h07FF); // cyan
      3:       bar_color = PXL_WIDTH'(16'h07E0); // green
      4:       bar_color = PXL_WIDTH'(16'hF81F); // magenta
      5:       bar_color = PXL_WIDTH'(16'hF800); // red
      6:       bar_color = PXL_WIDTH'(16'h001F); // blue
      default: bar_color = PXL_WIDTH'(16'h0000); // black
    endcase
    pix_nxt = i_test_mode ? bar_color : PXL_WIDTH'({hi_byte, data_s});
  end
`else
  always_comb pix_nxt = PXL_WIDTH'({hi_byte, data_s});
`endif

  assign o_present_state = state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      h_cnt        <= '0;
      v_cnt        <= '0;
      h_start_q    <= '0;
      v_start_q    <= '0;
      phase        <= 1'b0;
      hi_byte      <= '0;
      o_pixel_data <= '0;
      o_h_addr     <= '0;
      o_v_addr     <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (i_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (i_start_capture) state <= WAIT_VS;
          WAIT_VS: if (vs_rise) state <= VS_ACTIVE;
          VS_ACTIVE: if (vs_fall) begin
            state     <= CAPTURE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            phase     <= 1'b0;
            h_start_q <= i_h_start;
            v_start_q <= i_v_start;
          end
          CAPTURE: begin
            if (vs_rise) begin
              // new frame started before ours finished: report and resync
              o_frame_err <= 1'b1;
              state       <= VS_ACTIVE;
            end else if (hs_fall) begin
              h_cnt <= '0;
              if (v_cnt != '1) v_cnt <= v_cnt + 1'b1;
              if (v_last) begin
                state        <= DONE;
                o_frame_done <= 1'b1;
                o_frame_cnt  <= o_frame_cnt + 16'd1;
              end
            end else if (pclk_rise && hs_s) begin
              // a coincident HS rise restarts the byte pair on this byte
              if (!phase || hs_rise) begin
                hi_byte <= data_s;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (h_cnt != '1) h_cnt <= h_cnt + 1'b1;
                if (h_keep && v_keep) begin
                  o_valid      <= 1'b1;
                  o_pixel_data <= pix_nxt;
                  o_h_addr     <= h_addr_nxt;
                  o_v_addr     <= v_addr_nxt;
                end
              end
            end else if (hs_rise) begin
              phase <= 1'b0;
            end
          end
          DONE:    state <= i_continuous ? WAIT_VS : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
module tb_ov7670_frame_capture;

  logic       clk = 1'b0, rst = 1'b1, abort = 1'b0;
  logic       pclk = 1'b0, vs = 1'b0, hs = 1'b0;
  logic [7:0] data = 8'h00;
  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;

  // DUT A: 8x4 sensor, 4x2 output, decimation 2
  logic        a_start = 0, a_cont = 0;
  logic [2:0]  a_hs = 0;
  logic [1:0]  a_vs = 0;
  logic [15:0] a_pix, a_cnt;
  logic [2:0]  a_h, a_state;
  logic [1:0]  a_v;
  logic        a_valid, a_done, a_err;

  ov7670_frame_capture #(.SENS_H(8), .SENS_V(4), .OUT_H(4), .OUT_V(2),
                         .H_DECIM(2), .V_DECIM(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start_capture(a_start), .i_continuous(a_cont),
    .i_abort(abort), .i_h_start(a_hs), .i_v_start(a_vs),
    .i_PCLK(pclk), .i_VS(vs), .i_HS(hs), .i_DATA(data),
`ifdef OV7670_TEST_PATTERN_EN
    .i_test_mode(1'b0),
`endif
    .o_pixel_data(a_pix), .o_h_addr(a_h), .o_v_addr(a_v), .o_valid(a_valid),
    .o_present_state(a_state), .o_frame_done(a_done), .o_frame_err(a_err),
    .o_frame_cnt(a_cnt));

  // DUT B: same sensor, decimation 1 (crop test)
  logic        b_start = 0, b_cont = 0;
  logic [2:0]  b_hs = 0;
  logic [1:0]  b_vs = 0;
  logic [15:0] b_pix, b_cnt;
  logic [2:0]  b_h, b_state;
  logic [1:0]  b_v;
  logic        b_valid, b_done, b_err;

  ov7670_frame_capture #(.SENS_H(8), .SENS_V(4), .OUT_H(4), .OUT_V(2),
                         .H_DECIM(1), .V_DECIM(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start_capture(b_start), .i_continuous(b_cont),
    .i_abort(abort), .i_h_start(b_hs), .i_v_start(b_vs),
    .i_PCLK(pclk), .i_VS(vs), .i_HS(hs), .i_DATA(data),
`ifdef OV7670_TEST_PATTERN_EN
    .i_test_mode(1'b0),
`endif
    .o_pixel_data(b_pix), .o_h_addr(b_h), .o_v_addr(b_v), .o_valid(b_valid),
    .o_present_state(b_state), .o_frame_done(b_done), .o_frame_err(b_err),
    .o_frame_cnt(b_cnt));

  logic [15:0] qa_d[$], qb_d[$];
  int          qa_h[$], qa_v[$], qb_h[$], qb_v[$];
  int          a_done_n = 0, a_err_n = 0, b_done_n = 0;

  always @(negedge clk) begin
    if (a_valid) begin qa_d.push_back(a_pix); qa_h.push_back(int'(a_h)); qa_v.push_back(int'(a_v)); end
    if (b_valid) begin qb_d.push_back(b_pix); qb_h.push_back(int'(b_h)); qb_v.push_back(int'(b_v)); end
    if (a_done) a_done_n++;
    if (a_err)  a_err_n++;
    if (b_done) b_done_n++;
  end

`ifdef OV7670_TEST_PATTERN_EN
  // DUT C: 16-wide output, test pattern on
  logic        c_start = 0, c_tm = 0;
  logic [4:0]  c_hs = 0;
  logic [0:0]  c_vs = 0;
  logic [15:0] c_pix, c_cnt;
  logic [4:0]  c_h;
  logic [0:0]  c_v;
  logic [2:0]  c_state;
  logic        c_valid, c_done, c_err;
  logic [15:0] qc_d[$];
  int          qc_h[$];

  ov7670_frame_capture #(.SENS_H(32), .SENS_V(2), .OUT_H(16), .OUT_V(1),
                         .H_DECIM(1), .V_DECIM(1)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_start_capture(c_start), .i_continuous(1'b0),
    .i_abort(abort), .i_h_start(c_hs), .i_v_start(c_vs),
    .i_PCLK(pclk), .i_VS(vs), .i_HS(hs), .i_DATA(data), .i_test_mode(c_tm),
    .o_pixel_data(c_pix), .o_h_addr(c_h), .o_v_addr(c_v), .o_valid(c_valid),
    .o_present_state(c_state), .o_frame_done(c_done), .o_frame_err(c_err),
    .o_frame_cnt(c_cnt));

  always @(negedge clk)
    if (c_valid) begin qc_d.push_back(c_pix); qc_h.push_back(int'(c_h)); end
`endif

  // ---------------- stimulus helpers ----------------
  task automatic pclk_cycle();
    #40 pclk = 1'b1;
    #40 pclk = 1'b0;
  endtask

  // pat 0: every pixel is AB,CD; pat 1: high byte = line, low byte = column
  task automatic send_frame(input int nlines, input int ncols, input bit pat);
    vs = 1'b1; repeat (3) pclk_cycle();
    vs = 1'b0; repeat (3) pclk_cycle();
    for (int l = 0; l < nlines; l++) begin
      hs = 1'b1;
      for (int c = 0; c < ncols; c++) begin
        data = pat ? 8'(l) : 8'hAB; pclk_cycle();
        data = pat ? 8'(c) : 8'hCD; pclk_cycle();
      end
      hs = 1'b0; data = 8'h00;
      repeat (3) pclk_cycle();
    end
  endtask

  task automatic clear_mon();
    qa_d.delete(); qa_h.delete(); qa_v.delete();
    qb_d.delete(); qb_h.delete(); qb_v.delete();
    a_done_n = 0; a_err_n = 0; b_done_n = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    clear_mon();
  endtask

  task automatic start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_vec++;
    if ({a_pix, a_h, a_v, a_valid, a_state, a_done, a_err, a_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs=%h expected 0",
        {a_pix, a_h, a_v, a_valid, a_state, a_done, a_err, a_cnt});
    end
    n_vec++;
    if ({b_pix, b_h, b_v, b_valid, b_state, b_done, b_err, b_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs=%h expected 0",
        {b_pix, b_h, b_v, b_valid, b_state, b_done, b_err, b_cnt});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single_frame();
    clear_mon();
    start_a();
    n_vec++;
    if (a_state !== 3'd1) begin n_fail++; $display("FAIL arm_state: got %0d expected 1", a_state); end
    send_frame(4, 8, 0);
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (qa_d.size() != 8) begin n_fail++; $display("FAIL single_count: got %0d expected 8", qa_d.size()); end
    for (int i = 0; i < 8 && i < qa_d.size(); i++) begin
      n_vec++;
      if (qa_d[i] !== 16'hABCD || qa_h[i] != i % 4 || qa_v[i] != i / 4) begin
        n_fail++; $display("FAIL single_px%0d: got %h (%0d,%0d) expected abcd (%0d,%0d)",
          i, qa_d[i], qa_h[i], qa_v[i], i % 4, i / 4);
      end
    end
    n_vec++;
    if (a_done_n != 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", a_done_n); end
    n_vec++;
    if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", a_cnt); end
    n_vec++;
    if (a_state !== 3'd0) begin n_fail++; $display("FAIL single_idle: got %0d expected 0", a_state); end
  endtask

  task automatic test_continuous();
    do_reset();
    a_cont = 1'b1;
    start_a();
    for (int f = 0; f < 3; f++) begin
      send_frame(4, 8, 0);
      n_vec++;
      if (a_state !== 3'd1) begin n_fail++; $display("FAIL cont_rearm%0d: got %0d expected 1", f, a_state); end
    end
    n_vec++;
    if (qa_d.size() != 24) begin n_fail++; $display("FAIL cont_count: got %0d expected 24", qa_d.size()); end
    for (int i = 0; i < 24 && i < qa_d.size(); i += 5) begin
      n_vec++;
      if (qa_d[i] !== 16'hABCD || qa_h[i] != i % 4 || qa_v[i] != (i / 4) % 2) begin
        n_fail++; $display("FAIL cont_px%0d: got %h (%0d,%0d) expected abcd (%0d,%0d)",
          i, qa_d[i], qa_h[i], qa_v[i], i % 4, (i / 4) % 2);
      end
    end
    n_vec++;
    if (a_cnt !== 16'd3 || a_done_n != 3) begin
      n_fail++; $display("FAIL cont_cnt: got cnt %0d done %0d expected 3 3", a_cnt, a_done_n);
    end
    a_cont = 1'b0;
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_vec++;
    if (a_state !== 3'd0) begin n_fail++; $display("FAIL cont_abort: got %0d expected 0", a_state); end
  endtask

  task automatic test_crop();
    do_reset();
    b_hs = 3'd2; b_vs = 2'd1;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    send_frame(4, 8, 1);
    n_vec++;
    if (qb_d.size() != 8) begin n_fail++; $display("FAIL crop_count: got %0d expected 8", qb_d.size()); end
    n_vec++;
    if (qb_d.size() > 0 && (qb_d[0] !== 16'h0102 || qb_h[0] != 0 || qb_v[0] != 0)) begin
      n_fail++; $display("FAIL crop_first: got %h (%0d,%0d) expected 0102 (0,0)", qb_d[0], qb_h[0], qb_v[0]);
    end
    for (int i = 1; i < 8 && i < qb_d.size(); i++) begin
      n_vec++;
      if (qb_d[i] !== {8'(1 + i / 4), 8'(2 + i % 4)} || qb_h[i] != i % 4 || qb_v[i] != i / 4) begin
        n_fail++; $display("FAIL crop_px%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", i, qb_d[i],
          qb_h[i], qb_v[i], {8'(1 + i / 4), 8'(2 + i % 4)}, i % 4, i / 4);
      end
    end
    n_vec++;
    if (b_cnt !== 16'd1 || b_done_n != 1 || b_state !== 3'd0) begin
      n_fail++; $display("FAIL crop_done: got cnt %0d done %0d state %0d expected 1 1 0", b_cnt, b_done_n, b_state);
    end
  endtask

  task automatic test_truncated();
    do_reset();
    start_a();
    send_frame(1, 8, 0);
    n_vec++;
    if (qa_d.size() != 4 || a_state !== 3'd3 || a_cnt !== 16'd0) begin
      n_fail++; $display("FAIL trunc_partial: got %0d px state %0d cnt %0d expected 4 3 0", qa_d.size(), a_state, a_cnt);
    end
    send_frame(4, 8, 0);
    n_vec++;
    if (a_err_n != 1) begin n_fail++; $display("FAIL trunc_err: got %0d pulses expected 1", a_err_n); end
    n_vec++;
    if (a_cnt !== 16'd1 || a_done_n != 1 || a_state !== 3'd0) begin
      n_fail++; $display("FAIL trunc_recover: got cnt %0d done %0d state %0d expected 1 1 0", a_cnt, a_done_n, a_state);
    end
    n_vec++;
    if (qa_d.size() != 12 || (qa_d.size() == 12 && (qa_h[11] != 3 || qa_v[11] != 1 || qa_h[4] != 0 || qa_v[4] != 0))) begin
      n_fail++; $display("FAIL trunc_pixels: got %0d px expected 12 ending (3,1)", qa_d.size());
    end
  endtask

  task automatic test_abort_reset();
    int n_at = 0;
    clear_mon();
    start_a();
    fork
      send_frame(2, 8, 0);
      begin
        int t = 0;
        while (qa_d.size() < 2 && t < 5000) begin @(posedge clk); t++; end
        n_vec++;
        if (t >= 5000) begin n_fail++; $display("FAIL abort_wait: got timeout expected 2 pixels"); end
        @(negedge clk) abort = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (a_state !== 3'd0) begin n_fail++; $display("FAIL abort_idle: got %0d expected 0", a_state); end
        abort = 1'b0;
        n_at = qa_d.size();
      end
    join
    n_vec++;
    if (qa_d.size() != n_at) begin n_fail++; $display("FAIL abort_novalid: got %0d px expected %0d", qa_d.size(), n_at); end
    start_a();
    fork
      send_frame(2, 8, 0);
      begin
        int t = 0;
        while (qa_d.size() < n_at + 2 && t < 5000) begin @(posedge clk); t++; end
        n_vec++;
        if (t >= 5000) begin n_fail++; $display("FAIL rst_wait: got timeout expected 2 pixels"); end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({a_pix, a_h, a_v, a_valid, a_state, a_done, a_err, a_cnt} !== '0) begin
          n_fail++; $display("FAIL rst_async: outputs=%h expected 0",
            {a_pix, a_h, a_v, a_valid, a_state, a_done, a_err, a_cnt});
        end
        n_at = qa_d.size();
        #1000 rst = 1'b0;
      end
    join
    n_vec++;
    if (qa_d.size() != n_at || a_state !== 3'd0) begin
      n_fail++; $display("FAIL rst_after: got %0d px state %0d expected %0d 0", qa_d.size(), a_state, n_at);
    end
  endtask

`ifdef OV7670_TEST_PATTERN_EN
  task automatic test_pattern();
    logic [15:0] exp_c [8];
    exp_c = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    do_reset();
    qc_d.delete(); qc_h.delete();
    c_tm = 1'b1;
    @(negedge clk) c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    send_frame(1, 16, 0);
    n_vec++;
    if (qc_d.size() != 16) begin n_fail++; $display("FAIL tp_count: got %0d expected 16", qc_d.size()); end
    for (int i = 0; i < 16 && i < qc_d.size(); i++) begin
      n_vec++;
      if (qc_d[i] !== exp_c[i / 2] || qc_h[i] != i) begin
        n_fail++; $display("FAIL tp_px%0d: got %h @%0d expected %h @%0d", i, qc_d[i], qc_h[i], exp_c[i / 2], i);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_crop();
    test_truncated();
    test_abort_reset();
`ifdef OV7670_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
